// File: rtl/cordic_pkg.sv
// cordic_pkg: definitions shared by the CORDIC wrapper blocks.
//   quad_t    - sign-based quadrant code {y_sign, x_sign}
//   ANGLE_PI  - +/-pi at the default 16-bit angle width (MSB-only pattern)
//   sat_neg   - two's-complement negate that saturates the most-negative code
package cordic_pkg;

    typedef enum logic [1:0] {
        QUAD_Q1 = 2'b00,
        QUAD_Q2 = 2'b01,
        QUAD_Q4 = 2'b10,
        QUAD_Q3 = 2'b11
    } quad_t;

    localparam int ANGLE_W = 16;
    localparam logic [ANGLE_W-1:0] ANGLE_PI = {1'b1, {(ANGLE_W-1){1'b0}}};

    // Works on any width w <= 32. The caller sign-extends to 32 bits and
    // truncates the result back. Only the most-negative code of width w
    // would overflow, so it maps to +max.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v,
                                                   input int unsigned       w);
        logic signed [31:0] v_max;
        v_max = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (v < -v_max)
            return v_max;
        return -v;
    endfunction

endpackage

// File: rtl/vqc_delay_line.sv
// vqc_delay_line: fixed-depth, free-running shift register with async reset.
//   i_clk   - clock
//   i_rst_n - async active-low reset, clears every stage
//   i_d     - head input, loaded every cycle
//   o_q     - tail output, i_d delayed by DEPTH cycles
module vqc_delay_line #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vec_quad_corr.sv
// vec_quad_corr: quadrant pre-fold / angle post-correction around a
// vectoring-mode CORDIC core.
//   Pre stage : folds left-half-plane samples by pi, so the core only sees x >= 0,
//               and emits the quad code {y_sign, x_sign}.
//   Delay line: carries {valid, quad} alongside the core's latency.
//   Post stage: adds pi (MSB flip) to the core angle when the sample was folded.
// Ports:
//   clk, nreset            - clock, async active-low reset
//   enable, x_in, y_in     - input sample and its valid
//   x_out, y_out,
//   valid_out, quad_out    - folded sample to the core (1-cycle latency)
//   angle_in               - raw core angle, aligned with the delay-line tail
//   angle_out, quad_res,
//   angle_valid            - corrected angle (total latency CORDIC_STAGES+2)
//   core_valid_in          - core output valid (only with VQC_ALIGN_CHK_EN)
//   align_err              - sticky tail/core valid mismatch (0 without VQC_ALIGN_CHK_EN)
// Build option: define VQC_ALIGN_CHK_EN to enable the alignment checker.
// DATA_WIDTH must not exceed 32 (limit of the shared negate helper).
module vec_quad_corr
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          enable,
    input  logic signed [DATA_WIDTH-1:0]  x_in,
    input  logic signed [DATA_WIDTH-1:0]  y_in,
    output logic signed [DATA_WIDTH-1:0]  x_out,
    output logic signed [DATA_WIDTH-1:0]  y_out,
    output logic                          valid_out,
    output logic [1:0]                    quad_out,
    input  logic [ANGLE_WIDTH-1:0]        angle_in,
    output logic [ANGLE_WIDTH-1:0]        angle_out,
    output logic [1:0]                    quad_res,
    output logic                          angle_valid,
`ifdef VQC_ALIGN_CHK_EN
    input  logic                          core_valid_in,
`endif
    output logic                          align_err
);

    localparam logic [ANGLE_WIDTH-1:0] L_PI = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0]  r_x_out;
    logic signed [DATA_WIDTH-1:0]  r_y_out;
    logic                          r_valid_out;
    quad_t                         r_quad_out;
    logic [ANGLE_WIDTH-1:0]        r_angle_out;
    logic [1:0]                    r_quad_res;
    logic                          r_angle_valid;

    logic signed [DATA_WIDTH-1:0]  w_x_neg;
    logic signed [DATA_WIDTH-1:0]  w_y_neg;
    logic                          w_x_is_neg;
    logic [2:0]                    w_tail;
    logic                          w_tail_valid;
    logic [1:0]                    w_tail_quad;

    assign w_x_is_neg = x_in[DATA_WIDTH-1];
    assign w_x_neg    = DATA_WIDTH'(sat_neg(32'(x_in), DATA_WIDTH));
    assign w_y_neg    = DATA_WIDTH'(sat_neg(32'(y_in), DATA_WIDTH));

    // Pre stage: data loads every cycle; only valid_out qualifies it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_x_out     <= '0;
            r_y_out     <= '0;
            r_valid_out <= 1'b0;
            r_quad_out  <= QUAD_Q1;
        end else begin
            r_valid_out <= enable;
            r_quad_out  <= quad_t'({y_in[DATA_WIDTH-1], x_in[DATA_WIDTH-1]});
            if (w_x_is_neg) begin
                r_x_out <= w_x_neg;
                r_y_out <= w_y_neg;
            end else begin
                r_x_out <= x_in;
                r_y_out <= y_in;
            end
        end
    end

    vqc_delay_line #(
        .DEPTH (CORDIC_STAGES),
        .WIDTH (3)
    ) u_delay_line (
        .i_clk   (clk),
        .i_rst_n (nreset),
        .i_d     ({r_valid_out, r_quad_out}),
        .o_q     (w_tail)
    );

    assign w_tail_valid = w_tail[2];
    assign w_tail_quad  = w_tail[1:0];

    // Post stage: quad bit 0 records the fold, so undo it by adding pi.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_angle_out   <= '0;
            r_quad_res    <= 2'b00;
            r_angle_valid <= 1'b0;
        end else begin
            r_angle_valid <= w_tail_valid;
            r_quad_res    <= w_tail_quad;
            r_angle_out   <= w_tail_quad[0] ? (angle_in ^ L_PI) : angle_in;
        end
    end

`ifdef VQC_ALIGN_CHK_EN
    logic r_align_err;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            r_align_err <= 1'b0;
        else if (w_tail_valid != core_valid_in)
            r_align_err <= 1'b1;
    end

    assign align_err = r_align_err;
`else
    assign align_err = 1'b0;
`endif

    assign x_out       = r_x_out;
    assign y_out       = r_y_out;
    assign valid_out   = r_valid_out;
    assign quad_out    = r_quad_out;
    assign angle_out   = r_angle_out;
    assign quad_res    = r_quad_res;
    assign angle_valid = r_angle_valid;

endmodule

// File: doc/vec_quad_corr.md
Name: vec_quad_corr

Overview:
- Quadrant pre-fold and angle post-correction wrapper for CORDIC vectoring mode.
- Input side: folds a left-half-plane vector into the right half-plane and emits the 2-bit sign-based quad code consumed by rotation-mode quad handling.
- Output side: applies the ±pi angle correction to the CORDIC result, aligned through an internal delay line matching pipeline latency.
- Sits between the sample source and the vectoring CORDIC core, and between the core's angle output and downstream logic.

Parameters:
- DATA_WIDTH, 16, signed x/y width.
- ANGLE_WIDTH, 16, signed angle width; full scale 2^ANGLE_WIDTH = 2*pi, MSB weight = -pi.
- CORDIC_STAGES, 16, core latency in cycles from x_out/y_out to angle_in; also the delay-line depth.

Ports:
- clk  in  1  clock
- nreset  in  1  async active-low reset
- enable  in  1  input sample valid
- x_in  in  DATA_WIDTH  signed x
- y_in  in  DATA_WIDTH  signed y
- x_out  out  DATA_WIDTH  folded x to core, registered
- y_out  out  DATA_WIDTH  folded y to core, registered
- valid_out  out  1  x_out/y_out valid
- quad_out  out  2  {y_sign,x_sign} of the sample: 00 Q1, 01 Q2, 11 Q3, 10 Q4; registered with x_out
- angle_in  in  ANGLE_WIDTH  raw core angle, range (-pi/2, pi/2]
- angle_out  out  ANGLE_WIDTH  corrected angle, registered
- quad_res  out  2  quad code aligned with angle_out
- angle_valid  out  1  angle_out valid
- align_err  out  1  sticky alignment error (optional feature)

Behaviour:
- One clock: clk. Reset is asynchronous, active-low: nreset.
- Reset values: every output is 0, the delay line is all zeros, align_err is 0.
- Pre stage, 1-cycle latency, registered every cycle:
  - valid_out <= enable.
  - If x_in < 0: x_out <= -x_in and y_out <= -y_in (rotation by pi). Otherwise pass through unchanged.
  - Negating the most-negative value saturates to +max: -32768 -> 32767 at width 16.
  - quad_out <= {y_in[MSB], x_in[MSB]}.
  - When enable=0: data registers still load (don't-care), and valid_out=0.
  - Zero handling: x=0 and y=0 gives quad 00 with no fold. x=0 with y<0 gives quad 10 with no fold.
- Delay line:
  - Shift register of {valid, quad}, CORDIC_STAGES entries deep.
  - Shifts every cycle, never stalls; the core is free-running.
  - Head is loaded from valid_out/quad_out.
  - Tail is aligned with angle_in.
- Post stage, 1-cycle latency:
  - angle_valid <= tail.valid.
  - quad_res <= tail.quad.
  - If tail.quad[0]=1 (x was negative): angle_out <= angle_in + pi mod 2^ANGLE_WIDTH, i.e. invert the MSB. Otherwise angle_out <= angle_in.
  - Data registers load regardless of valid.
- Total latency x_in -> angle_out: CORDIC_STAGES + 2 cycles.
- Throughput: one sample per cycle; back-to-back samples are required.
- Reset mid-operation: all in-flight entries are discarded. angle_valid stays 0 until CORDIC_STAGES+2 cycles after the first post-reset enable.

Optional Feature:
- Macro: VQC_ALIGN_CHK_EN.
- Defined:
  - Extra input core_valid_in (1 bit), the core's own output valid.
  - Each cycle, tail.valid != core_valid_in sets align_err=1.
  - align_err is sticky until nreset.
- Undefined: no core_valid_in port, and align_err is tied to 0.

Decomposition:
- Shared package cordic_pkg holds:
  - quad code typedef (2-bit enum Q1=00, Q2=01, Q3=11, Q4=10);
  - ANGLE_PI constant (MSB-only pattern);
  - a saturating-negate function.
- One sub-module, vqc_delay_line: parameterized depth/width shift register with async reset, reusable by other CORDIC blocks.

Test Plan:
- Reset: hold nreset=0 with random inputs -> all outputs 0. Release, drive enable=0 for 40 cycles -> angle_valid stays 0.
- Q1: (x,y)=(100,50), enable 1 cycle -> next cycle x_out=100, y_out=50, quad_out=00. Inject angle_in=0x12E4 at tail -> angle_out=0x12E4, quad_res=00, 18 cycles after the input.
- Q2: (-100,50) -> x_out=100, y_out=-50, quad_out=01. angle_in=0xE000 (-pi/4) -> angle_out=0x6000 (3pi/4).
- Q3: (-100,-50) -> x_out=100, y_out=50, quad_out=11. angle_in=0x2000 -> angle_out=0xA000 (-3pi/4). Q4 (100,-50): quad 10, angle unchanged.
- Saturation: (-32768,-32768) -> x_out=32767, y_out=32767, quad_out=11. Back-to-back: 20 consecutive mixed-quadrant samples -> each quad_res and correction matches its own sample, in order, with no gaps.
- Mid-stream reset: assert nreset for 1 cycle with 8 samples in flight -> no angle_valid for those samples. With VQC_ALIGN_CHK_EN, skewing core_valid_in by 1 cycle -> align_err=1 and it stays set.
